// File: rtl/bombe_pkg.sv
// Shared constants and state encodings for the bombe rotor stepper and
// the rotor FSM debug decode.
package bombe_pkg;

    localparam int ROTOR_W       = 5;
    localparam int NUM_POSITIONS = 26;
    localparam int TOTAL_STEPS   = 17576;
    localparam int POS_W         = 3 * ROTOR_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_LOAD    = 3'b001,
        ST_WAIT    = 3'b010,
        ST_PRESS   = 3'b011,
        ST_RELEASE = 3'b100,
        ST_DONE    = 3'b101
    } stepper_state_e;

endpackage

// File: rtl/rotor_odometer.sv
// Shadow copy of the three rotor positions: load-time correction,
// mod-N increment on commit and odometer carry (step mask) generation.
module rotor_odometer
    import bombe_pkg::*;
#(
    parameter int MODULUS = 26
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [POS_W-1:0] load_value,
    input  logic             commit,
    input  logic [2:0]       commit_mask,
    output logic [POS_W-1:0] position,
    output logic [2:0]       step_mask
);

    localparam logic [ROTOR_W-1:0] LAST = ROTOR_W'(MODULUS - 1);

    logic [ROTOR_W-1:0] r0, r1, r2;

    // Out-of-range load values (MODULUS..31) are forced to position 0.
    function automatic logic [ROTOR_W-1:0] correct(input logic [ROTOR_W-1:0] v);
        return (v > LAST) ? '0 : v;
    endfunction

    function automatic logic [ROTOR_W-1:0] wrap_inc(input logic [ROTOR_W-1:0] v);
        return (v == LAST) ? '0 : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
        end else if (load) begin
            r0 <= correct(load_value[ROTOR_W-1:0]);
            r1 <= correct(load_value[2*ROTOR_W-1:ROTOR_W]);
            r2 <= correct(load_value[3*ROTOR_W-1:2*ROTOR_W]);
        end else if (commit) begin
            if (commit_mask[0]) r0 <= wrap_inc(r0);
            if (commit_mask[1]) r1 <= wrap_inc(r1);
            if (commit_mask[2]) r2 <= wrap_inc(r2);
        end
    end

    assign position  = {r2, r1, r0};
    assign step_mask = {(r0 == LAST) && (r1 == LAST), r0 == LAST, 1'b1};

endmodule

// File: rtl/bombe_rotor_stepper.sv
// Drives three rotors through every position in odometer order, one
// press/release increment per accepted advance, with a shadow position copy.
module bombe_rotor_stepper
    import bombe_pkg::*;
#(
    parameter int PRESS_CYCLES  = 1,
    parameter int NUM_POSITIONS = bombe_pkg::NUM_POSITIONS
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic             advance,
    input  logic [POS_W-1:0] init_pos,
    output logic             advance_ready,
    output logic [2:0]       rotor_increment,
    output logic             rotor_load,
    output logic [POS_W-1:0] rotor_init,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done,
    output logic [2:0]       current_state
);

    stepper_state_e state, state_next;
    logic [3:0]     press_cnt;
    logic [14:0]    step_cnt;
    logic [2:0]     mask;
    logic [2:0]     step_mask;
    logic           stop_latch;
    logic           idle_like, load_accept, start_accept, advance_accept, press_last;

    assign idle_like      = (state == ST_IDLE) || (state == ST_DONE);
    assign load_accept    = idle_like && load;
    assign start_accept   = idle_like && start && !load;
    assign advance_accept = (state == ST_WAIT) && !stop && !stop_latch && advance;
    assign press_last     = (state == ST_PRESS) && (press_cnt == 4'(PRESS_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (load)       state_next = ST_LOAD;
                else if (start) state_next = ST_WAIT;
            end
            ST_LOAD: state_next = ST_IDLE;
            ST_WAIT: begin
                if (stop || stop_latch) state_next = ST_IDLE;
                else if (advance)       state_next = ST_PRESS;
            end
            ST_PRESS: begin
                if (press_last) state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_next = (step_cnt == 15'(TOTAL_STEPS)) ? ST_DONE : ST_WAIT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A stop seen mid-step is deferred until the step has fully released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            press_cnt  <= '0;
            step_cnt   <= '0;
            mask       <= '0;
            stop_latch <= 1'b0;
        end else begin
            if (start_accept) begin
                step_cnt   <= '0;
                stop_latch <= 1'b0;
            end
            if (stop && ((state == ST_PRESS) || (state == ST_RELEASE)))
                stop_latch <= 1'b1;
            if (advance_accept) begin
                mask      <= step_mask;
                press_cnt <= '0;
            end else if ((state == ST_PRESS) && !press_last) begin
                press_cnt <= press_cnt + 1'b1;
            end
            if (press_last)
                step_cnt <= step_cnt + 1'b1;
        end
    end

    rotor_odometer #(
        .MODULUS(NUM_POSITIONS)
    ) u_odometer (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load_accept),
        .load_value (init_pos),
        .commit     (press_last),
        .commit_mask(mask),
        .position   (position),
        .step_mask  (step_mask)
    );

    // The shadow already holds the corrected load value during LOAD.
    always_comb begin
        advance_ready   = (state == ST_WAIT);
        rotor_increment = (state == ST_PRESS) ? mask : 3'b000;
        rotor_load      = (state == ST_LOAD);
        rotor_init      = (state == ST_LOAD) ? position : '0;
        busy            = !idle_like;
        done            = (state == ST_DONE);
        current_state   = state;
    end

endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// Directed bench for bombe_rotor_stepper: one instance with a 1-cycle press
// and one with a 3-cycle press share the stimulus.
module tb_bombe_rotor_stepper;

    logic        clk = 1'b0;
    logic        resetn, load, start, stop, advance;
    logic [14:0] init_pos;

    logic        advance_ready, rotor_load, busy, done;
    logic [2:0]  rotor_increment, current_state;
    logic [14:0] rotor_init, position;

    logic        advance_ready_3, rotor_load_3, busy_3, done_3;
    logic [2:0]  rotor_increment_3, current_state_3;
    logic [14:0] rotor_init_3, position_3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bombe_rotor_stepper #(.PRESS_CYCLES(1), .NUM_POSITIONS(26)) dut (
        .clk(clk), .resetn(resetn), .load(load), .start(start), .stop(stop),
        .advance(advance), .init_pos(init_pos), .advance_ready(advance_ready),
        .rotor_increment(rotor_increment), .rotor_load(rotor_load),
        .rotor_init(rotor_init), .position(position), .busy(busy),
        .done(done), .current_state(current_state)
    );

    bombe_rotor_stepper #(.PRESS_CYCLES(3), .NUM_POSITIONS(26)) dut3 (
        .clk(clk), .resetn(resetn), .load(load), .start(start), .stop(stop),
        .advance(advance), .init_pos(init_pos), .advance_ready(advance_ready_3),
        .rotor_increment(rotor_increment_3), .rotor_load(rotor_load_3),
        .rotor_init(rotor_init_3), .position(position_3), .busy(busy_3),
        .done(done_3), .current_state(current_state_3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] pos3(input int r2, input int r1, input int r0);
        return {5'(r2), 5'(r1), 5'(r0)};
    endfunction

    task automatic load_pos(input logic [14:0] p);
        init_pos = p;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    int steps, streak, bad_low, cycles;

    initial begin
        resetn = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; advance = 1'b0;
        init_pos = '0;
        tick();
        check("reset_state", 32'(current_state), 0);
        check("reset_position", 32'(position), 0);
        check("reset_increment", 32'(rotor_increment), 0);
        resetn = 1'b1;
        tick();

        // load with an out-of-range r0 field
        init_pos = pos3(2, 5, 31);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("load_strobe", 32'(rotor_load), 1);
        check("load_state", 32'(current_state), 1);
        check("load_init", 32'(rotor_init), 32'(pos3(2, 5, 0)));
        check("load_position", 32'(position), 32'(pos3(2, 5, 0)));
        tick();
        check("load_strobe_drop", 32'(rotor_load), 0);
        check("load_back_idle", 32'(current_state), 0);

        // two single steps from {0,0,24}
        load_pos(pos3(0, 0, 24));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", 32'(advance_ready), 1);
        check("start_busy", 32'(busy), 1);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check("step1_inc", 32'(rotor_increment), 32'b001);
        tick();
        check("step1_release", 32'(rotor_increment), 0);
        check("step1_position", 32'(position), 32'(pos3(0, 0, 25)));
        tick();
        check("step1_ready", 32'(advance_ready), 1);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check("step2_inc", 32'(rotor_increment), 32'b011);
        tick();
        check("step2_position", 32'(position), 32'(pos3(0, 1, 0)));
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_in_wait", 32'(current_state), 0);

        // full carry from {25,25,25}
        load_pos(pos3(25, 25, 25));
        start = 1'b1;
        tick();
        start = 1'b0;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check("carry_inc", 32'(rotor_increment), 32'b111);
        tick();
        check("carry_position", 32'(position), 0);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // full run with advance held high
        load_pos(pos3(0, 0, 0));
        start = 1'b1;
        tick();
        start = 1'b0;
        advance = 1'b1;
        steps = 0; streak = 0; bad_low = 0; cycles = 0;
        while (!done && cycles < 60000) begin
            tick();
            cycles++;
            if (rotor_increment != 3'b000) steps++;
            if (!advance_ready) streak++;
            else begin
                if (streak != 0 && streak != 2) bad_low++;
                streak = 0;
            end
        end
        advance = 1'b0;
        check("run_done", 32'(done), 1);
        check("run_steps", 32'(steps), 17576);
        check("run_position", 32'(position), 0);
        check("run_ready_low", 32'(bad_low), 0);
        check("run_done_state", 32'(current_state), 32'b101);
        tick();
        check("run_done_holds", 32'(done), 1);

        // 3-cycle press with stop mid-press
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        load_pos(pos3(0, 0, 7));
        start = 1'b1;
        tick();
        start = 1'b0;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check("p3_inc_c1", 32'(rotor_increment_3), 32'b001);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("p3_inc_c2", 32'(rotor_increment_3), 32'b001);
        tick();
        check("p3_inc_c3", 32'(rotor_increment_3), 32'b001);
        check("p3_pos_hold", 32'(position_3), 32'(pos3(0, 0, 7)));
        tick();
        check("p3_release", 32'(rotor_increment_3), 0);
        check("p3_position", 32'(position_3), 32'(pos3(0, 0, 8)));
        tick();
        advance = 1'b1;
        tick();
        check("p3_stopped", 32'(current_state_3), 0);
        check("p3_no_pulse", 32'(rotor_increment_3), 0);
        tick();
        advance = 1'b0;
        check("p3_no_pulse_late", 32'(rotor_increment_3), 0);

        // asynchronous reset in the middle of a press
        load_pos(pos3(0, 0, 3));
        start = 1'b1;
        tick();
        start = 1'b0;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check("ar_pre_inc", 32'(rotor_increment_3), 32'b001);
        #2 resetn = 1'b0;
        #1;
        check("ar_inc", 32'(rotor_increment_3), 0);
        check("ar_position", 32'(position_3), 0);
        check("ar_state", 32'(current_state_3), 0);
        #1 resetn = 1'b1;
        tick();

        // load and start together: load wins
        init_pos = pos3(1, 2, 3);
        load = 1'b1;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        check("ls_state", 32'(current_state), 1);
        check("ls_position", 32'(position), 32'(pos3(1, 2, 3)));
        tick();
        check("ls_idle", 32'(current_state), 0);
        check("ls_busy", 32'(busy), 0);
        tick();
        check("ls_still_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
